// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the CPU controller and the ALU execution unit.
interface alu_exec_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [2:0]         AluOP;
  logic [5:0]         Func;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [SHAMT_W-1:0] Shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   Result;
  logic               Zero;
  logic               err;

  modport master (
    output start, AluOP, Func, A, B, Shamt,
    input  busy, done, Result, Zero, err
  );

  modport slave (
    input  start, AluOP, Func, A, B, Shamt,
    output busy, done, Result, Zero, err
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shifts and shift-add MULT.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int MUL_EN  = 1
) (
  input  logic            clk,
  input  logic            reset,
  alu_exec_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_SRL, OP_MUL, OP_ILL
  } aluOp_e;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL} state_e;

  state_e           state, stateNxt;
  aluOp_e           op;
  logic [WIDTH-1:0] quickRes;
  logic             isShift, shiftLong;
  logic [CNT_W-1:0] cntLoad;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opA, opB, acc;
  logic             dirLeft;
  logic [WIDTH-1:0] shiftNext, accNext;
  logic             busyC, lastStep;
  logic             doneR, zeroR, errR;
  logic [WIDTH-1:0] resR;

  // Decode AluOP/Func into an operation, in controller priority order
  always_comb begin
    op = OP_ILL;
    case (bus.AluOP)
      3'b000: op = OP_ADD;
      3'b001: op = OP_SUB;
      3'b100: op = OP_AND;
      3'b101: op = OP_OR;
      3'b110: op = OP_SLT;
      3'b010: begin
        case (bus.Func)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b101010: op = OP_SLT;
          6'b000000: op = OP_SLL;
          6'b000010: op = OP_SRL;
          6'b011000: op = (MUL_EN != 0) ? OP_MUL : OP_ILL;
          default:   op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  // Single-cycle result; a zero-distance shift simply passes B through
  always_comb begin
    quickRes = '0;
    case (op)
      OP_ADD:         quickRes = bus.A + bus.B;
      OP_SUB:         quickRes = bus.A - bus.B;
      OP_AND:         quickRes = bus.A & bus.B;
      OP_OR:          quickRes = bus.A | bus.B;
      OP_SLT:         quickRes = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLL, OP_SRL: quickRes = bus.B;
      default:        quickRes = '0;
    endcase
  end

  // Shift distance clamps to WIDTH: that many zero-fill steps already clear the word
  always_comb begin
    isShift   = (op == OP_SLL) || (op == OP_SRL);
    shiftLong = isShift && (bus.Shamt != '0);
    if (int'(bus.Shamt) >= WIDTH) cntLoad = CNT_W'(WIDTH);
    else                          cntLoad = CNT_W'(bus.Shamt);
  end

  // One-bit shift step and one shift-add multiply step
  always_comb begin
    shiftNext = dirLeft ? {opB[WIDTH-2:0], 1'b0} : {1'b0, opB[WIDTH-1:1]};
    accNext   = opB[0] ? (acc + opA) : acc;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNxt;
  end

  // Next-state: long ops leave IDLE, iterative states exit on the last counted step
  always_comb begin
    stateNxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (op == OP_MUL)   stateNxt = ST_MUL;
          else if (shiftLong) stateNxt = ST_SHIFT;
        end
      end
      ST_SHIFT: if (cnt == CNT_W'(1)) stateNxt = ST_IDLE;
      ST_MUL:   if (cnt == CNT_W'(1)) stateNxt = ST_IDLE;
      default:  stateNxt = ST_IDLE;
    endcase
  end

  // FSM outputs: busy only while iterating, so it is already low in the done cycle
  always_comb begin
    busyC    = (state != ST_IDLE);
    lastStep = busyC && (cnt == CNT_W'(1));
  end

  // Datapath and registered outputs; Result/Zero/err move only with done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opA     <= '0;
      opB     <= '0;
      acc     <= '0;
      cnt     <= '0;
      dirLeft <= 1'b0;
      doneR   <= 1'b0;
      resR    <= '0;
      zeroR   <= 1'b1;
      errR    <= 1'b0;
    end else begin
      doneR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (op == OP_MUL) begin
              opA <= bus.A;
              opB <= bus.B;
              acc <= '0;
              cnt <= CNT_W'(WIDTH);
            end else if (shiftLong) begin
              opB     <= bus.B;
              cnt     <= cntLoad;
              dirLeft <= (op == OP_SLL);
            end else begin
              doneR <= 1'b1;
              resR  <= quickRes;
              zeroR <= (quickRes == '0);
              errR  <= (op == OP_ILL);
            end
          end
        end
        ST_SHIFT: begin
          opB <= shiftNext;
          cnt <= cnt - CNT_W'(1);
          if (lastStep) begin
            doneR <= 1'b1;
            resR  <= shiftNext;
            zeroR <= (shiftNext == '0);
            errR  <= 1'b0;
          end
        end
        ST_MUL: begin
          acc <= accNext;
          opA <= {opA[WIDTH-2:0], 1'b0};
          opB <= {1'b0, opB[WIDTH-1:1]};
          cnt <= cnt - CNT_W'(1);
          if (lastStep) begin
            doneR <= 1'b1;
            resR  <= accNext;
            zeroR <= (accNext == '0);
            errR  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busyC;
  assign bus.done   = doneR;
  assign bus.Result = resR;
  assign bus.Zero   = zeroR;
  assign bus.err    = errR;
endmodule
